stopwatch_ctrl: RTL

//  Run/pause/clear/lap sequencer for the cs/sec/min stopwatch datapath on the DE1 board.

---
 rtl/stopwatch_pkg.sv | 20 ++
 rtl/stopwatch_ctrl_btn_edge.sv | 31 +++
 rtl/stopwatch_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and limits for the stopwatch sequencer (stopwatch_ctrl) and its bench.
// The optional lap/display-hold feature is selected with STOPWATCH_LAP_EN.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_FULL  = 2'd3
   } state_e;

   localparam int CS_MAX  = 99;
   localparam int SEC_MAX = 59;
   localparam int MIN_MAX = 59;

   function automatic int calc_div(input int clk_hz, input int tick_hz);
      return clk_hz / tick_hz;
   endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_edge.sv
// Button conditioner: two-flop synchroniser followed by a registered rising-edge pulse.
// The pulse appears two clocks after the first sampling edge, so the FSM acts one edge later.
module btn_edge (
   input  logic clk_i,
   input  logic rst_i,
   input  logic btn_i,
   output logic rise_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;
   logic rise_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         meta_q <= btn_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
         rise_q <= sync_q & ~prev_q;
      end
   end

   assign rise_o = rise_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear/lap sequencer for the cs/sec/min stopwatch datapath.
// Define STOPWATCH_LAP_EN to enable the lap button and display hold; otherwise disp_hold is 0.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int CLK_HZ  = 50_000_000,
   parameter int TICK_HZ = 100
) (
   input  logic   CLOCK_50,
   input  logic   reset,
   input  logic   start_btn,
   input  logic   clear_btn,
   input  logic   lap_btn,
   input  logic   cs_tc,
   input  logic   sec_tc,
   input  logic   min_tc,
   output logic   cnt_clr,
   output logic   cs_en,
   output logic   sec_en,
   output logic   min_en,
   output logic   running,
   output logic   full,
   output logic   disp_hold,
   output state_e dbg_state
);

   localparam int DIV   = calc_div(CLK_HZ, TICK_HZ);
   localparam int DIV_W = $clog2(DIV);
   localparam logic [DIV_W-1:0] PRESC_TOP = DIV_W'(DIV - 1);

   state_e            state_q, state_d;
   logic [DIV_W-1:0]  presc_q, presc_d;
   logic              start_rise;
   logic              clear_rise;
   logic              tick;
   logic              last;
   logic              clr;

   btn_edge u_start (.clk_i(CLOCK_50), .rst_i(reset), .btn_i(start_btn), .rise_o(start_rise));
   btn_edge u_clear (.clk_i(CLOCK_50), .rst_i(reset), .btn_i(clear_btn), .rise_o(clear_rise));

   assign tick = (state_q == ST_RUN) && (presc_q == PRESC_TOP);
   assign last = cs_tc & sec_tc & min_tc;

   // Clear beats start wherever clear is legal; in RUN clear is ignored and start pauses.
   // A terminal tick in RUN goes to FULL even if start arrives in the same cycle.
   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      clr     = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_PAUSE: begin
            if (clear_rise) begin
               state_d = ST_IDLE;
               clr     = 1'b1;
            end else if (start_rise) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (tick && last) begin
               state_d = ST_FULL;
            end else if (start_rise) begin
               state_d = ST_PAUSE;
            end
         end
         ST_FULL: begin
            if (clear_rise) begin
               state_d = ST_IDLE;
               clr     = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (clr) begin
         presc_d = '0;
      end else if (state_q == ST_RUN) begin
         presc_d = tick ? '0 : presc_q + 1'b1;
      end
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         presc_q <= '0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
      end
   end

`ifdef STOPWATCH_LAP_EN
   logic lap_rise;
   logic hold_q, hold_d;

   btn_edge u_lap (.clk_i(CLOCK_50), .rst_i(reset), .btn_i(lap_btn), .rise_o(lap_rise));

   // Hold toggles only while running; a lap press while stopped releases the view.
   always_comb begin
      hold_d = hold_q;
      if (lap_rise) begin
         if (state_q == ST_RUN) begin
            hold_d = ~hold_q;
         end else if (state_q != ST_IDLE) begin
            hold_d = 1'b0;
         end
      end
      if (clr) begin
         hold_d = 1'b0;
      end
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         hold_q <= 1'b0;
      end else begin
         hold_q <= hold_d;
      end
   end

   assign disp_hold = hold_q;
`else
   logic lap_unused;
   assign lap_unused = lap_btn;
   assign disp_hold  = 1'b0;
`endif

   assign cs_en     = tick & ~last;
   assign sec_en    = cs_en & cs_tc;
   assign min_en    = sec_en & sec_tc;
   assign cnt_clr   = clr;
   assign running   = (state_q == ST_RUN);
   assign full      = (state_q == ST_FULL);
   assign dbg_state = state_q;

endmodule
